idex_stage_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS pipeline. It sits directly downstream of the opcode control decoder and the register file. Each cycle it captures the decoded control bundle and operands of the instruction in ID and presents them to EX. It detects lw→dependent-instruction hazards, inserts a one-cycle bubble, and kills the ID instruction on a branch/jump flush.

---
 rtl/idex_stage_reg.sv | 108 ++++++++++
 tb/tb_idex_stage_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS pipeline.
// Detects load-use hazards, inserts bubbles and kills the ID instruction on a flush.
module idex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [9:0]        id_ctrl,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [9:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  logic              valid_q, valid_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [9:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rdata1_q, rdata2_q, imm_q, pc4_q;
  logic [4:0]        rs_q, rt_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic rs_hit, rt_hit, hz, kill;

  // Only R-type, sw and beq actually read rt; j ignores the rs field.
  always_comb begin
    rs_hit = (rt_q == id_rs) && (id_opcode != OpJ);
    rt_hit = (rt_q == id_rt) && (id_opcode inside {OpRtype, OpSw, OpBeq});
    hz     = id_valid && valid_q && ctrl_q[5] && (rt_q != 5'd0) && (rs_hit || rt_hit);
    stall  = hz && !flush;
    kill   = flush || hz || !id_valid;
  end

  always_comb begin
    valid_d  = !kill;
    opcode_d = kill ? 6'd0 : id_opcode;
    ctrl_d   = kill ? 10'd0 : id_ctrl;
    cnt_d    = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Data fields load unconditionally; a bubble is defined solely by valid/ctrl.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      opcode_q <= '0;
      ctrl_q   <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      imm_q    <= '0;
      pc4_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      ctrl_q   <= ctrl_d;
      rdata1_q <= id_rdata1;
      rdata2_q <= id_rdata2;
      imm_q    <= id_imm;
      pc4_q    <= id_pc4;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      rd_q     <= id_rd;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_opcode   = opcode_q;
  assign ex_ctrl     = ctrl_q;
  assign ex_rdata1   = rdata1_q;
  assign ex_rdata2   = rdata2_q;
  assign ex_imm      = imm_q;
  assign ex_pc4      = pc4_q;
  assign ex_rs       = rs_q;
  assign ex_rt       = rt_q;
  assign ex_rd       = rd_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Scoreboard bench for idex_stage_reg: the driver queues expected per-cycle results,
// a monitor checks stall mid-cycle and the EX registers just after each edge.
module tb_idex_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [9:0] C_ADD = 10'b1001000010;
  localparam logic [9:0] C_LW  = 10'b0111100000;
  localparam logic [9:0] C_SW  = 10'b0100010000;
  localparam logic [9:0] C_J   = 10'b0000000100;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          id_valid;
  logic [5:0]    id_opcode;
  logic [9:0]    id_ctrl;
  logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          flush;
  logic          ex_valid;
  logic [5:0]    ex_opcode;
  logic [9:0]    ex_ctrl;
  logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [4:0]    ex_rs, ex_rt, ex_rd;
  logic          stall;
  logic [CW-1:0] stall_count;

  idex_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ctrl(id_ctrl), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_ctrl(ex_ctrl),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            stall;
    bit            valid;
    logic [9:0]    ctrl;
    bit            chk_data;
    logic [5:0]    op;
    logic [DW-1:0] r1, r2, imm, pc4;
    logic [4:0]    rs, rt, rd;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One ID cycle: drive inputs, queue what stall must read now and what EX holds after the edge.
  task automatic cyc(input bit rn, input bit v, input logic [5:0] op, input logic [9:0] ctrl,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [31:0] r1, input bit fl, input bit e_stall, input bit e_cap,
                     input logic [CW-1:0] e_cnt);
    exp_t e;
    reset_n   = rn;
    id_valid  = v;
    id_opcode = op;
    id_ctrl   = ctrl;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    id_rdata1 = r1;
    id_rdata2 = r1 + 32'd1;
    id_imm    = r1 + 32'd2;
    id_pc4    = r1 + 32'd4;
    flush     = fl;
    e.stall   = e_stall;
    if (!rn) begin
      e.valid = 1'b0; e.ctrl = '0; e.chk_data = 1'b1; e.op = '0;
      e.r1 = '0; e.r2 = '0; e.imm = '0; e.pc4 = '0;
      e.rs = '0; e.rt = '0; e.rd = '0; e.cnt = '0;
    end else begin
      e.valid = e_cap; e.ctrl = e_cap ? ctrl : 10'd0; e.chk_data = e_cap; e.op = op;
      e.r1 = r1; e.r2 = r1 + 32'd1; e.imm = r1 + 32'd2; e.pc4 = r1 + 32'd4;
      e.rs = rs; e.rt = rt; e.rd = rd; e.cnt = e_cnt;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        chk("stall_count", 32'(stall_count), 32'(e.cnt));
        if (e.chk_data) begin
          chk("ex_opcode", 32'(ex_opcode), 32'(e.op));
          chk("ex_rdata1", ex_rdata1, e.r1);
          chk("ex_rdata2", ex_rdata2, e.r2);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_pc4", ex_pc4, e.pc4);
          chk("ex_rs", 32'(ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(ex_rt), 32'(e.rt));
          chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        end
      end
    end
  end

  // Driver
  initial begin
    logic [CW-1:0] c;
    reset_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_ctrl = '0; flush = 1'b0;
    id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_pc4 = '0;
    id_rs = '0; id_rt = '0; id_rd = '0;
    @(posedge clk);
    #2;
    // reset with random ID contents
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 6'($urandom), 10'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 4'd0);
    end
    // rn v  op      ctrl   rs     rt     rd     r1           fl    stall cap   cnt
    cyc(1, 1, OP_ADD, C_ADD, 5'd1,  5'd2,  5'd3,  32'h11,      1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1, 1, OP_LW,  C_LW,  5'd1,  5'd5,  5'd0,  32'h100,     1'b0, 1'b0, 1'b1, 4'd0);
    cyc(1, 1, OP_ADD, C_ADD, 5'd5,  5'd6,  5'd7,  32'h22,      1'b0, 1'b1, 1'b0, 4'd1);
    cyc(1, 1, OP_ADD, C_ADD, 5'd5,  5'd6,  5'd7,  32'h22,      1'b0, 1'b0, 1'b1, 4'd1);
    cyc(1, 1, OP_LW,  C_LW,  5'd2,  5'd5,  5'd0,  32'h200,     1'b0, 1'b0, 1'b1, 4'd1);
    // lw rt match is not a use
    cyc(1, 1, OP_LW,  C_LW,  5'd7,  5'd5,  5'd0,  32'h300,     1'b0, 1'b0, 1'b1, 4'd1);
    cyc(1, 1, OP_LW,  C_LW,  5'd3,  5'd0,  5'd0,  32'h400,     1'b0, 1'b0, 1'b1, 4'd1);
    // lw to $0 never stalls
    cyc(1, 1, OP_ADD, C_ADD, 5'd0,  5'd9,  5'd4,  32'h33,      1'b0, 1'b0, 1'b1, 4'd1);
    cyc(1, 1, OP_LW,  C_LW,  5'd1,  5'd8,  5'd0,  32'h500,     1'b0, 1'b0, 1'b1, 4'd1);
    // sw reads rt
    cyc(1, 1, OP_SW,  C_SW,  5'd3,  5'd8,  5'd0,  32'h44,      1'b0, 1'b1, 1'b0, 4'd2);
    cyc(1, 1, OP_SW,  C_SW,  5'd3,  5'd8,  5'd0,  32'h44,      1'b0, 1'b0, 1'b1, 4'd2);
    cyc(1, 1, OP_LW,  C_LW,  5'd0,  5'd4,  5'd0,  32'h600,     1'b0, 1'b0, 1'b1, 4'd2);
    // j ignores its rs field
    cyc(1, 1, OP_J,   C_J,   5'd4,  5'd0,  5'd0,  32'h55,      1'b0, 1'b0, 1'b1, 4'd2);
    cyc(1, 1, OP_LW,  C_LW,  5'd0,  5'd6,  5'd0,  32'h700,     1'b0, 1'b0, 1'b1, 4'd2);
    // flush beats the hazard
    cyc(1, 1, OP_ADD, C_ADD, 5'd6,  5'd1,  5'd2,  32'h66,      1'b1, 1'b0, 1'b0, 4'd2);
    cyc(1, 1, OP_ADD, C_ADD, 5'd6,  5'd1,  5'd2,  32'h66,      1'b0, 1'b0, 1'b1, 4'd2);
    cyc(1, 0, OP_ADD, C_ADD, 5'd6,  5'd1,  5'd2,  32'h77,      1'b0, 1'b0, 1'b0, 4'd2);
    cyc(1, 1, OP_LW,  C_LW,  5'd0,  5'd3,  5'd0,  32'h800,     1'b0, 1'b0, 1'b1, 4'd2);
    // 20 load-use pairs drive the 4-bit counter into saturation
    c = 4'd2;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, OP_LW, C_LW, 5'd0, 5'd5, 5'd0, 32'h1000 + 32'(i), 1'b0, 1'b0, 1'b1, c);
      if (c != 4'd15) c = c + 4'd1;
      cyc(1, 1, OP_ADD, C_ADD, 5'd5, 5'd1, 5'd9, 32'h2000 + 32'(i), 1'b0, 1'b1, 1'b0, c);
    end
    chk("sat_value", 32'(c), 32'd15);
    // reset in the middle of a stall
    cyc(1, 1, OP_LW,  C_LW,  5'd0,  5'd5,  5'd0,  32'h900,     1'b0, 1'b0, 1'b1, 4'd15);
    cyc(0, 1, OP_ADD, C_ADD, 5'd5,  5'd1,  5'd9,  32'h88,      1'b0, 1'b1, 1'b0, 4'd0);
    cyc(1, 1, OP_ADD, C_ADD, 5'd5,  5'd1,  5'd9,  32'h88,      1'b0, 1'b0, 1'b1, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
